// File: rtl/alu_result_stage.sv
// Registered result stage behind adder_subber: derives Zero/Negative, queues
// results in a small FIFO, keeps sticky Carry/Overflow and an accumulator.
module alu_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      Sum,
  input  logic             Carry,
  input  logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      Result,
  output logic [3:0]       Flags,
  output logic [15:0]      Acc,
  output logic [1:0]       Sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] Count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic [15:0] sum;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        acc_q, acc_d;
  logic [1:0]         sticky_q, sticky_d;
  logic               push, pop;

  // in_ready looks only at occupancy, so a full FIFO refuses a push even when
  // the consumer pops in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head   = mem_q[rd_ptr_q];
  assign Result = out_valid ? head.sum : 16'h0000;
  assign Flags  = out_valid ? {head.negative, head.zero, head.overflow, head.carry} : 4'b0000;
  assign Acc    = acc_q;
  assign Sticky = sticky_q;
  assign Count  = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    acc_d    = acc_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      acc_d    = Sum;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A flag arriving with clr_sticky wins over the clear.
    sticky_d = {(sticky_q[1] & ~clr_sticky) | (push & Overflow),
                (sticky_q[0] & ~clr_sticky) | (push & Carry)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      sticky_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observed through
  // the gated read while Count is non-zero, so their reset value never matters.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{negative: Sum[15], zero: (Sum == 16'h0000),
                           overflow: Overflow, carry: Carry, sum: Sum};
    end
  end

endmodule
